// File: rtl/sdram_pixel_writer.sv
// rtl/sdram_pixel_writer.sv - buffers a 24-bit pixel stream and writes it to SDRAM
// in granted bursts of single-word WRITE commands, addressing the frame linearly.
module sdram_pixel_writer #(
  parameter int          BURST_LEN  = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [21:0] FRAME_BASE = 22'd0,
  parameter int          FRAME_PX   = 384000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] pix_data,
  input  logic        pix_sof,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        flush,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [1:0]  command,
  output logic [21:0] data_address,
  output logic [31:0] data_write,
  input  logic        data_write_done,
  output logic        frame_done,
  output logic        busy
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = AW + 1;
  localparam int          BW        = $clog2(BURST_LEN) + 1;
  localparam logic [21:0] LAST_ADDR = FRAME_BASE + 22'(FRAME_PX - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_LOAD, S_WRITE} state_t;

  logic [24:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;
  logic [BW-1:0] burst_q, load_words;
  logic [21:0]   next_addr_q, data_address_q, addr_after, load_addr;
  logic [31:0]   data_write_q;
  logic [1:0]    command_q;
  logic          bus_req_q, frame_done_q;
  logic          push, pop, at_last;
  logic [24:0]   head;

  assign pix_ready  = (count_q < CW'(FIFO_DEPTH));
  assign push       = pix_valid && pix_ready;
  assign pop        = (state_q == S_LOAD) ||
                      (state_q == S_WRITE && data_write_done && burst_q > BW'(1));
  assign head       = mem_q[rd_ptr_q];
  assign at_last    = (data_address_q == LAST_ADDR);
  assign addr_after = at_last ? FRAME_BASE : data_address_q + 22'd1;
  // A back-to-back load continues from the word just completed, not the stale next_addr_q.
  assign load_addr  = head[24] ? FRAME_BASE :
                      ((state_q == S_WRITE) ? addr_after : next_addr_q);
  assign load_words = (count_q >= CW'(BURST_LEN)) ? BW'(BURST_LEN) : BW'(count_q);

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (!push && pop)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {pix_sof, pix_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      burst_q        <= '0;
      next_addr_q    <= FRAME_BASE;
      data_address_q <= FRAME_BASE;
      data_write_q   <= '0;
      command_q      <= 2'd0;
      bus_req_q      <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (count_q >= CW'(BURST_LEN) || (flush && count_q != '0)) begin
            state_q   <= S_REQ;
            bus_req_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus_grant)
            state_q <= S_LOAD;
        end
        S_LOAD: begin
          data_address_q <= load_addr;
          data_write_q   <= {8'h00, head[23:0]};
          burst_q        <= load_words;
          command_q      <= 2'd1;
          state_q        <= S_WRITE;
        end
        S_WRITE: begin
          if (data_write_done) begin
            next_addr_q  <= addr_after;
            frame_done_q <= at_last;
            burst_q      <= burst_q - BW'(1);
            if (burst_q > BW'(1)) begin
              data_address_q <= load_addr;
              data_write_q   <= {8'h00, head[23:0]};
            end else begin
              command_q <= 2'd0;
              bus_req_q <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_req      = bus_req_q;
  assign command      = command_q;
  assign data_address = data_address_q;
  assign data_write   = data_write_q;
  assign frame_done   = frame_done_q;
  assign busy         = (state_q != S_IDLE) || (count_q != '0);
endmodule

// File: doc/sdram_pixel_writer.md
Name: sdram_pixel_writer

Overview:
- Write-side counterpart of the SDRAM-to-LCD read path. Accepts a 24-bit pixel stream from the fractal compute engine and buffers it in a small synchronous FIFO.
- Issues single-word CMD_WRITE sequences to the as4c4m32s_controller command interface in bursts of BURST_LEN, storing the frame linearly at FRAME_BASE.
- Shares the controller with the read path through a req/grant handshake. Runs entirely in the MEM_CLK domain.

Parameters:
- BURST_LEN, 8, words written per granted burst (power of 2, ≤ FIFO_DEPTH).
- FIFO_DEPTH, 16, internal pixel buffer depth (power of 2).
- FRAME_BASE, 0, first SDRAM word address of the frame (22 bits).
- FRAME_PX, 384000, pixels per frame (800*480).

Ports:
- clk  in  1  MEM_CLK domain clock
- reset_n  in  1  asynchronous active-low reset
- pix_data  in  24  RGB pixel
- pix_sof  in  1  pixel is the first of a frame (address rewinds to FRAME_BASE)
- pix_valid  in  1  pixel present
- pix_ready  out  1  buffer can accept a pixel this cycle
- flush  in  1  level; write out a partial burst when the buffer is non-empty
- bus_req  out  1  request for the controller
- bus_grant  in  1  controller granted to this block
- command  out  2  0 = IDLE, 1 = WRITE (this block never issues READ)
- data_address  out  22  SDRAM word address
- data_write  out  32  {8'h00, pixel}
- data_write_done  in  1  controller accepted the current word
- frame_done  out  1  one-cycle pulse when the word at FRAME_BASE+FRAME_PX-1 completes
- busy  out  1  state ≠ IDLE or buffer non-empty

Behaviour:
- Reset (asynchronous, any state):
  - command=0, bus_req=0, data_address=FRAME_BASE, data_write=0, frame_done=0.
  - Buffer emptied; next_addr=FRAME_BASE; state=IDLE.
  - Clears any burst in progress immediately; no further done pulses are counted.
- Buffer:
  - 25-bit entries {sof, pixel}.
  - pix_ready = (count < FIFO_DEPTH), registered-count based.
  - Push on pix_valid && pix_ready. Simultaneous push and pop leaves count unchanged.
  - Never overflows. Pop on an empty buffer is impossible by construction.
- FSM states: IDLE, REQ, LOAD, WRITE.
  - IDLE → REQ when count ≥ BURST_LEN, or flush && count > 0. bus_req=1 from REQ until leaving WRITE.
  - REQ → LOAD when bus_grant=1. Hold in REQ indefinitely otherwise.
  - LOAD (1 cycle):
    - Pop the head entry.
    - data_address = head.sof ? FRAME_BASE : next_addr.
    - data_write = {8'h00, head.pixel}.
    - Set burst counter = words for this burst: BURST_LEN, or min(count, BURST_LEN) when triggered by flush.
    - command=WRITE from the next cycle.
  - WRITE: hold command, data_address and data_write stable until data_write_done.
    - On done: next_addr = (data_address == FRAME_BASE+FRAME_PX-1) ? FRAME_BASE : data_address+1.
    - frame_done pulses for 1 cycle if data_address was the last pixel.
    - Decrement the burst counter.
    - If words remain: pop the next entry and load the outputs the same cycle (back-to-back, no LOAD bubble).
    - Otherwise: command=IDLE, bus_req=0, state=IDLE.
- Burst word count is fixed at LOAD. Pixels pushed during a burst are not appended to it.
- bus_grant is sampled only in REQ. Deassertion during WRITE is ignored (the arbiter must not revoke mid-burst).
- An sof entry in mid-burst rewinds the address for that word; subsequent words continue from FRAME_BASE+1.
- Address arithmetic is 22-bit. The wrap compare is exact equality, never overflow.

Test Plan:
- Reset, then push 8 pixels 0x000001..0x000008 with grant tied high.
  - REQ within 1 cycle of the 8th push.
  - 8 writes at addresses 0..7, data 0x00000001..0x00000008.
  - Controller done every 3rd cycle; command returns to 0 after the 8th done.
- Push 20 pixels without grant.
  - pix_ready falls after 16 accepted; bus_req=1.
  - Grant: 8 words written, pix_ready rises, remaining pixels accepted in order.
- Push 3 pixels, assert flush.
  - Exactly 3 writes at next_addr..next_addr+2; buffer empty; busy=0 afterward.
- Preset next_addr to 383998 (stream 383998 pixels first or force), then write 4 pixels.
  - Addresses 383998, 383999, 0, 1.
  - frame_done pulses once, on the done for 383999.
- Send pixel with pix_sof as 5th of a burst starting at address 100.
  - Addresses 100..103, then 0..3.
- Assert reset_n=0 mid-WRITE (after 3 dones).
  - command=0 and bus_req=0 asynchronously.
  - After release: buffer empty, data_address=FRAME_BASE, pix_ready=1.
